icache_fetch_responder: RTL and testbench

Instruction-cache responder on the fetch side of the instruction buffer. Each cycle it takes the buffer's fetch request (PC, instruction count) and combinationally returns up to `N_WAY consecutive cached instructions as a contiguous valid prefix, with a hit count. On a miss it fetches the missing 64-bit line from instruction memory over the tagged `BUS_LOAD` protocol and installs it in a direct-mapped line array.

---
 rtl/icache_pkg.sv | 28 ++
 rtl/icache_fetch_responder_if.sv | 31 +++
 rtl/icache_fill_ctrl.sv | 71 +++++++
 rtl/icache_fetch_responder.sv | 86 ++++++++
 tb/tb_icache_fetch_responder.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared types and sizing for the instruction-cache fetch responder.
package icache_pkg;

    localparam int XLEN        = 32;
    localparam int N_WAY       = 3;
    localparam int CNT_W       = $clog2(N_WAY) + 1;
    localparam int CACHE_LINES = 32;
    localparam int IDX_W       = $clog2(CACHE_LINES);
    localparam int TAG_W       = XLEN - 3 - IDX_W;

    typedef enum logic [1:0] {
        BUS_NONE = 2'h0,
        BUS_LOAD = 2'h1
    } bus_cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } icache_state_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [63:0]      data;
    } icache_line_t;

endpackage

// File: rtl/icache_fetch_responder_if.sv
// Fetch-buffer and instruction-memory signals of the I-cache responder.
interface icache_fetch_responder_if;
    import icache_pkg::*;

    logic [XLEN-1:0]             buff2Icache_addr;
    logic [CNT_W-1:0]            buff2Icache_count;
    logic [N_WAY-1:0][XLEN-1:0]  Icache2buff_addr;
    logic [N_WAY-1:0][XLEN-1:0]  Icache2buff_data;
    logic [N_WAY-1:0]            Icache2buff_valid;
    logic [CNT_W-1:0]            Icache2buff_hit_count;
    logic [1:0]                  proc2Imem_command;
    logic [XLEN-1:0]             proc2Imem_addr;
    logic [3:0]                  Imem2proc_response;
    logic [63:0]                 Imem2proc_data;
    logic [3:0]                  Imem2proc_tag;

    modport slave (
        input  buff2Icache_addr, buff2Icache_count,
        input  Imem2proc_response, Imem2proc_data, Imem2proc_tag,
        output Icache2buff_addr, Icache2buff_data, Icache2buff_valid, Icache2buff_hit_count,
        output proc2Imem_command, proc2Imem_addr
    );

    modport master (
        output buff2Icache_addr, buff2Icache_count,
        output Imem2proc_response, Imem2proc_data, Imem2proc_tag,
        input  Icache2buff_addr, Icache2buff_data, Icache2buff_valid, Icache2buff_hit_count,
        input  proc2Imem_command, proc2Imem_addr
    );

endinterface

// File: rtl/icache_fill_ctrl.sv
// Miss-fill sequencer: one outstanding tagged BUS_LOAD at a time, then a line write.
module icache_fill_ctrl
    import icache_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             miss_valid,
    input  logic [XLEN-1:0]  miss_line_addr,
    input  logic [3:0]       mem_response,
    input  logic [3:0]       mem_tag_in,
    output bus_cmd_e         mem_command,
    output logic [XLEN-1:0]  mem_addr,
    output logic             fill_we,
    output logic [IDX_W-1:0] fill_idx,
    output logic [TAG_W-1:0] fill_tag
);

    icache_state_e   state_q, state_d;
    logic [XLEN-1:0] miss_addr_q, miss_addr_d;
    logic [3:0]      mem_tag_q, mem_tag_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            mem_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            mem_tag_q   <= mem_tag_d;
        end
    end

    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        mem_tag_d   = mem_tag_q;
        mem_command = BUS_NONE;
        fill_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    miss_addr_d = miss_line_addr;
                    state_d     = REQ;
                end
            end
            REQ: begin
                mem_command = BUS_LOAD;
                if (mem_response != 4'd0) begin
                    mem_tag_d = mem_response;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (mem_tag_in == mem_tag_q) begin
                    fill_we   = 1'b1;
                    mem_tag_d = 4'd0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr = miss_addr_q;
    assign fill_idx = miss_addr_q[3 +: IDX_W];
    assign fill_tag = miss_addr_q[XLEN-1 -: TAG_W];

endmodule

// File: rtl/icache_fetch_responder.sv
// Direct-mapped instruction cache answering N_WAY-wide fetch lookups combinationally.
module icache_fetch_responder
    import icache_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    icache_fetch_responder_if.slave  bus
);

    icache_line_t     lines_q [CACHE_LINES];
    icache_line_t     lines_d [CACHE_LINES];
    logic [XLEN-1:0]  slot_addr [N_WAY];
    icache_line_t     slot_line [N_WAY];
    logic [N_WAY-1:0] slot_hit;
    logic [N_WAY-1:0] valid_vec;
    logic [CNT_W-1:0] req_count;
    logic [CNT_W-1:0] hit_count;
    logic             prefix_ok;
    logic             miss_valid;
    logic [XLEN-1:0]  miss_line_addr;
    bus_cmd_e         mem_command;
    logic             fill_we;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;

    icache_fill_ctrl u_fill_ctrl (
        .clock          (clock),
        .reset          (reset),
        .miss_valid     (miss_valid),
        .miss_line_addr (miss_line_addr),
        .mem_response   (bus.Imem2proc_response),
        .mem_tag_in     (bus.Imem2proc_tag),
        .mem_command    (mem_command),
        .mem_addr       (bus.proc2Imem_addr),
        .fill_we        (fill_we),
        .fill_idx       (fill_idx),
        .fill_tag       (fill_tag)
    );

    assign bus.proc2Imem_command = mem_command;

    always_comb begin
        req_count      = (bus.buff2Icache_count > CNT_W'(N_WAY)) ? CNT_W'(N_WAY) : bus.buff2Icache_count;
        prefix_ok      = 1'b1;
        hit_count      = '0;
        valid_vec      = '0;
        miss_valid     = 1'b0;
        miss_line_addr = '0;
        for (int i = 0; i < N_WAY; i++) begin
            slot_addr[i] = (bus.buff2Icache_addr & ~XLEN'(3)) + XLEN'(4 * i);
            slot_line[i] = lines_q[slot_addr[i][3 +: IDX_W]];
            slot_hit[i]  = slot_line[i].valid && (slot_line[i].tag == slot_addr[i][XLEN-1 -: TAG_W]);
            bus.Icache2buff_addr[i] = slot_addr[i];
            bus.Icache2buff_data[i] = slot_addr[i][2] ? slot_line[i].data[63:32] : slot_line[i].data[31:0];
            // A miss in any requested slot breaks the prefix for every slot after it.
            prefix_ok    = prefix_ok && (CNT_W'(i) < req_count) && slot_hit[i];
            valid_vec[i] = prefix_ok;
            hit_count    = hit_count + CNT_W'(prefix_ok);
            if (!miss_valid && (CNT_W'(i) < req_count) && !slot_hit[i]) begin
                miss_valid     = 1'b1;
                miss_line_addr = slot_addr[i] & ~XLEN'(7);
            end
        end
        bus.Icache2buff_valid     = valid_vec;
        bus.Icache2buff_hit_count = hit_count;
    end

    always_comb begin
        lines_d = lines_q;
        if (fill_we) begin
            lines_d[fill_idx] = '{valid: 1'b1, tag: fill_tag, data: bus.Imem2proc_data};
        end
    end

    // NOTE: only the valid bits are reset; tag and data are don't-care until a fill sets valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CACHE_LINES; i++) begin
                lines_q[i].valid <= 1'b0;
            end
        end else begin
            lines_q <= lines_d;
        end
    end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed and randomized checks of the I-cache responder against a line-address model.
module tb_icache_fetch_responder;
    import icache_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    icache_fetch_responder_if bus ();

    icache_fetch_responder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: per index, whether it holds a line, which line address, and its data.
    bit          m_valid [CACHE_LINES];
    logic [31:0] m_line  [CACHE_LINES];
    logic [63:0] m_data  [CACHE_LINES];

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] pc, input int cnt);
        bus.buff2Icache_addr  = pc;
        bus.buff2Icache_count = CNT_W'(cnt);
    endtask

    task automatic check_lookup(input string name, input logic [2:0] exp_valid, input int exp_hits);
        check({name, "_valid"}, bus.Icache2buff_valid, exp_valid);
        check({name, "_hits"}, bus.Icache2buff_hit_count, exp_hits);
    endtask

    // Called at the sample point of the first REQ cycle; returns at the sample point after the fill.
    task automatic serve(input string name, input logic [31:0] exp_addr, input int busy,
                         input logic [3:0] tg, input int lat, input logic [63:0] data);
        for (int b = 0; b <= busy; b++) begin
            check({name, "_cmd_load"}, bus.proc2Imem_command, BUS_LOAD);
            check({name, "_req_addr"}, bus.proc2Imem_addr, exp_addr);
            bus.Imem2proc_response = (b == busy) ? tg : 4'd0;
            tick();
            bus.Imem2proc_response = 4'd0;
            @(negedge clock);
        end
        for (int l = 1; l < lat; l++) begin
            check({name, "_cmd_idle"}, bus.proc2Imem_command, BUS_NONE);
            bus.Imem2proc_tag = tg + 4'd1;
            tick();
            bus.Imem2proc_tag = 4'd0;
            @(negedge clock);
        end
        check({name, "_cmd_data"}, bus.proc2Imem_command, BUS_NONE);
        bus.Imem2proc_tag  = tg;
        bus.Imem2proc_data = data;
        tick();
        bus.Imem2proc_tag = 4'd0;
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] pc;
        int          cnt;
        int          n;
        bit          run;
        int          hits;
        logic [2:0]  exp_valid;
        bit          pending;
        bit          accepted;
        logic [31:0] m_miss;
        logic [3:0]  m_tag;
        int          m_lat;
        bit          install;
        logic [63:0] fill_data;
        logic [31:0] first_miss;
        bit          have_miss;

        reset                  = 1'b1;
        bus.buff2Icache_addr   = '0;
        bus.buff2Icache_count  = '0;
        bus.Imem2proc_response = '0;
        bus.Imem2proc_data     = '0;
        bus.Imem2proc_tag      = '0;

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_cmd", bus.proc2Imem_command, BUS_NONE);
        check("rst_addr", bus.proc2Imem_addr, 32'h0);
        check_lookup("rst", 3'b000, 0);

        // Cold miss at 0x0.
        tick();
        drive_req(32'h0, 3);
        @(negedge clock);
        check_lookup("cold_m", 3'b000, 0);
        check("cold_m_cmd", bus.proc2Imem_command, BUS_NONE);
        tick();
        @(negedge clock);
        serve("cold", 32'h0, 0, 4'd3, 5, 64'h00100013_00200093);
        check_lookup("cold_hit", 3'b011, 2);
        check("cold_d0", bus.Icache2buff_data[0], 32'h00200093);
        check("cold_d1", bus.Icache2buff_data[1], 32'h00100013);
        check("cold_a2", bus.Icache2buff_addr[2], 32'h8);
        check("cold_after_cmd", bus.proc2Imem_command, BUS_NONE);
        tick();
        @(negedge clock);

        // Memory busy for three cycles while fetching line 0x8.
        serve("busy", 32'h8, 3, 4'd9, 2, 64'h11111111_22222222);
        check_lookup("busy_hit", 3'b111, 3);
        check("busy_d2", bus.Icache2buff_data[2], 32'h22222222);

        // Count above N_WAY clamps.
        tick();
        drive_req(32'h0, 7);
        @(negedge clock);
        check_lookup("clamp", 3'b111, 3);

        // Evict line 0 with 0x100, then the prefix rule at 0x4.
        tick();
        drive_req(32'h100, 1);
        @(negedge clock);
        check_lookup("evict_m", 3'b000, 0);
        tick();
        @(negedge clock);
        serve("evict", 32'h100, 0, 4'd2, 1, 64'hAAAA5555_BBBB6666);
        check_lookup("evict_hit", 3'b001, 1);
        check("evict_d0", bus.Icache2buff_data[0], 32'hBBBB6666);
        tick();
        drive_req(32'h4, 3);
        @(negedge clock);
        check_lookup("prefix", 3'b000, 0);
        tick();
        drive_req(32'h0, 0);
        @(negedge clock);
        check("prefix_cmd", bus.proc2Imem_command, BUS_LOAD);
        check("prefix_addr", bus.proc2Imem_addr, 32'h0);
        bus.Imem2proc_response = 4'd5;
        tick();
        bus.Imem2proc_response = 4'd0;
        @(negedge clock);
        check("wait_cmd", bus.proc2Imem_command, BUS_NONE);

        // Reset in WAIT; the stale tag must not write, and count=0 requests nothing.
        tick();
        reset = 1'b1;
        tick();
        reset              = 1'b0;
        bus.Imem2proc_tag  = 4'd5;
        bus.Imem2proc_data = 64'hDEADBEEF_DEADBEEF;
        @(negedge clock);
        check_lookup("cnt0", 3'b000, 0);
        check("post_rst_cmd", bus.proc2Imem_command, BUS_NONE);
        tick();
        bus.Imem2proc_tag = 4'd0;
        drive_req(32'h0, 1);
        @(negedge clock);
        check_lookup("stale", 3'b000, 0);
        check("cnt0_noreq", bus.proc2Imem_command, BUS_NONE);
        tick();
        @(negedge clock);
        serve("refill0", 32'h0, 1, 4'd7, 3, 64'h00500093_00400013);
        check_lookup("refill0_hit", 3'b001, 1);
        check("refill0_d0", bus.Icache2buff_data[0], 32'h00400013);

        // Wrap-around past the top of the address space.
        tick();
        drive_req(32'hFFFF_FFFE, 3);
        @(negedge clock);
        check("wrap_a0", bus.Icache2buff_addr[0], 32'hFFFF_FFFC);
        check("wrap_a1", bus.Icache2buff_addr[1], 32'h0);
        check("wrap_a2", bus.Icache2buff_addr[2], 32'h4);
        check_lookup("wrap_m", 3'b000, 0);
        tick();
        @(negedge clock);
        serve("wrap", 32'hFFFF_FFF8, 0, 4'd12, 2, 64'hCAFEF00D_12345678);
        check_lookup("wrap_hit", 3'b111, 3);
        check("wrap_d0", bus.Icache2buff_data[0], 32'hCAFEF00D);
        check("wrap_d1", bus.Icache2buff_data[1], 32'h00400013);
        check("wrap_d2", bus.Icache2buff_data[2], 32'h00500093);

        // Randomized traffic against the line-address model.
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < CACHE_LINES; i++) m_valid[i] = 1'b0;
        pending  = 1'b0;
        accepted = 1'b0;
        m_miss   = '0;
        m_tag    = '0;
        m_lat    = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            case ($urandom_range(0, 3))
                0:       pc = $urandom_range(0, 32'h3FF);
                1:       pc = 32'h400 | $urandom_range(0, 32'hFF);
                2:       pc = 32'hFFFF_FFE0 | $urandom_range(0, 31);
                default: pc = $urandom;
            endcase
            cnt = $urandom_range(0, 7);
            drive_req(pc, cnt);
            install = 1'b0;
            @(negedge clock);

            n         = (cnt > N_WAY) ? N_WAY : cnt;
            run       = 1'b1;
            hits      = 0;
            have_miss = 1'b0;
            first_miss = '0;
            exp_valid = '0;
            for (int s = 0; s < N_WAY; s++) begin
                logic [31:0] a;
                logic [31:0] line;
                int          idx;
                bit          hit;
                a    = (pc & ~32'd3) + 32'(4 * s);
                line = a >> 3;
                idx  = int'(line % CACHE_LINES);
                hit  = m_valid[idx] && (m_line[idx] == line);
                check("rnd_addr", bus.Icache2buff_addr[s], a);
                run = run && (s < n) && hit;
                exp_valid[s] = run;
                if (run) begin
                    hits++;
                    check("rnd_data", bus.Icache2buff_data[s], a[2] ? m_data[idx][63:32] : m_data[idx][31:0]);
                end
                if (!have_miss && (s < n) && !hit) begin
                    have_miss  = 1'b1;
                    first_miss = line << 3;
                end
            end
            check_lookup("rnd", exp_valid, hits);

            if (pending && !accepted) begin
                check("rnd_cmd_load", bus.proc2Imem_command, BUS_LOAD);
                check("rnd_req_addr", bus.proc2Imem_addr, m_miss);
                bus.Imem2proc_response = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                bus.Imem2proc_tag      = 4'($urandom_range(0, 15));
                if (bus.Imem2proc_response != 4'd0) begin
                    accepted = 1'b1;
                    m_tag    = bus.Imem2proc_response;
                    m_lat    = $urandom_range(1, 4);
                end
            end else begin
                check("rnd_cmd_none", bus.proc2Imem_command, BUS_NONE);
                if (accepted) begin
                    m_lat--;
                    if (m_lat == 0) begin
                        fill_data          = {$urandom, $urandom};
                        bus.Imem2proc_tag  = m_tag;
                        bus.Imem2proc_data = fill_data;
                        install            = 1'b1;
                    end else begin
                        bus.Imem2proc_tag = m_tag + 4'($urandom_range(1, 15));
                    end
                end else begin
                    bus.Imem2proc_tag = 4'($urandom_range(0, 15));
                    if (have_miss) begin
                        pending = 1'b1;
                        m_miss  = first_miss;
                    end
                end
            end

            tick();
            bus.Imem2proc_response = 4'd0;
            bus.Imem2proc_tag      = 4'd0;
            if (install) begin
                m_valid[(m_miss >> 3) % CACHE_LINES] = 1'b1;
                m_line[(m_miss >> 3) % CACHE_LINES]  = m_miss >> 3;
                m_data[(m_miss >> 3) % CACHE_LINES]  = fill_data;
                pending  = 1'b0;
                accepted = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
